// File: rtl/flog_pkg.sv
// Shared definitions for the flop event logging buffer.
// Level encodings, record layout and record width helper.
package flog_pkg;

  typedef enum logic [1:0] {
    LVL_DEBUG   = 2'd0,
    LVL_INFO    = 2'd1,
    LVL_WARNING = 2'd2,
    LVL_ERROR   = 2'd3
  } flog_lvl_e;

  localparam int REC_I_BIT   = 0;
  localparam int REC_O_BIT   = 1;
  localparam int REC_LVL_LSB = 2;
  localparam int REC_TS_LSB  = 4;

  function automatic int rec_width(input int ts_w);
    return ts_w + REC_TS_LSB;
  endfunction

endpackage

// File: rtl/flog_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Head entry is visible on o_data whenever not empty, else zero.
module flog_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/flog_event_buffer.sv
// Capture stage for clock-enabled flop logging: filters by level,
// timestamps accepted events and queues them for a ready/valid consumer.
module flog_event_buffer
  import flog_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int TS_WIDTH   = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                             CLK,
  input  logic                             ASYNCRESETN,
  input  logic                             CE,
  input  logic                             I,
  input  logic                             O,
  input  logic [1:0]                       LVL,
  input  logic [1:0]                       THRESH,
  output logic                             REC_VALID,
  input  logic                             REC_READY,
  output logic [rec_width(TS_WIDTH)-1:0]   REC_DATA,
  output logic [$clog2(DEPTH):0]           COUNT,
  output logic [DROP_WIDTH-1:0]            DROP_CNT,
  input  logic                             CLR_DROP
);

  localparam int RW = rec_width(TS_WIDTH);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

  logic [TS_WIDTH-1:0]   r_ts;
  logic [DROP_WIDTH-1:0] r_drop;
  logic [RW-1:0]         w_rec;
  logic                  w_qual;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;

  assign w_qual = CE & (LVL >= THRESH);
  assign w_pop  = REC_VALID & REC_READY;
  assign w_drop = w_qual & w_full & ~w_pop;

  // Assemble the record from this cycle's sample and timestamp.
  always_comb begin
    w_rec = '0;
    w_rec[REC_I_BIT] = I;
    w_rec[REC_O_BIT] = O;
    w_rec[REC_LVL_LSB +: 2] = LVL;
    w_rec[REC_TS_LSB +: TS_WIDTH] = r_ts;
  end

  // Free-running timestamp, independent of CE.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) r_ts <= '0;
    else              r_ts <= r_ts + TS_WIDTH'(1);
  end

  // Saturating drop counter; a clear coinciding with a drop leaves one.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_drop <= '0;
    end else if (CLR_DROP) begin
      r_drop <= w_drop ? DROP_WIDTH'(1) : '0;
    end else if (w_drop && r_drop != DROP_MAX) begin
      r_drop <= r_drop + DROP_WIDTH'(1);
    end
  end

  flog_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (ASYNCRESETN),
    .i_push  (w_qual),
    .i_pop   (w_pop),
    .i_data  (w_rec),
    .o_data  (REC_DATA),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (COUNT)
  );

  assign REC_VALID = ~w_empty;
  assign DROP_CNT  = r_drop;

endmodule

// File: tb/tb_flog_event_buffer.sv
// Directed self-checking bench for flog_event_buffer.
// Scenario tasks run in sequence from one initial block.
module tb_flog_event_buffer;

  logic        CLK = 1'b0;
  logic        ASYNCRESETN;
  logic        CE, I, O;
  logic [1:0]  LVL, THRESH;
  logic        REC_VALID;
  logic        REC_READY;
  logic [19:0] REC_DATA;
  logic [3:0]  COUNT;
  logic [7:0]  DROP_CNT;
  logic        CLR_DROP;

  int checks = 0;
  int fails  = 0;
  logic [15:0] ts_now;
  logic [19:0] q[$];

  always #5 CLK = ~CLK;

  flog_event_buffer dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .CE          (CE),
    .I           (I),
    .O           (O),
    .LVL         (LVL),
    .THRESH      (THRESH),
    .REC_VALID   (REC_VALID),
    .REC_READY   (REC_READY),
    .REC_DATA    (REC_DATA),
    .COUNT       (COUNT),
    .DROP_CNT    (DROP_CNT),
    .CLR_DROP    (CLR_DROP)
  );

  function automatic logic [19:0] mk(input logic [15:0] t,
                                     input logic [1:0] l,
                                     input logic o, input logic i);
    return {t, l, o, i};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    ts_now = ts_now + 16'd1;
  endtask

  task automatic release_rst();
    @(posedge CLK);
    #1;
    ASYNCRESETN = 1'b1;
    ts_now = 16'd0;
  endtask

  task automatic drain();
    CE = 1'b0;
    REC_READY = 1'b1;
    for (int k = 0; k < 20 && COUNT != 0; k++) step();
    checks++;
    if (COUNT !== 4'd0) begin
      fails++;
      $display("FAIL drain: COUNT=%0d required 0", COUNT);
    end
    REC_READY = 1'b0;
  endtask

  task automatic test_reset();
    ASYNCRESETN = 1'b0;
    CE = 0; I = 0; O = 0; LVL = 0; THRESH = 0;
    REC_READY = 0; CLR_DROP = 0;
    ts_now = 0;
    step(); step();
    checks++;
    if (REC_VALID !== 1'b0 || COUNT !== 4'd0 || DROP_CNT !== 8'd0
        || REC_DATA !== 20'd0) begin
      fails++;
      $display("FAIL reset: valid=%b count=%0d drop=%0d data=%h required 0",
               REC_VALID, COUNT, DROP_CNT, REC_DATA);
    end
  endtask

  task automatic test_first_event();
    release_rst();
    CE = 1; I = 1; O = 0; LVL = 2'd1; THRESH = 0;
    step();
    CE = 0;
    checks++;
    if (REC_VALID !== 1'b1 || REC_DATA !== 20'h00005 || COUNT !== 4'd1) begin
      fails++;
      $display("FAIL first_event: valid=%b data=%h count=%0d required 1 00005 1",
               REC_VALID, REC_DATA, COUNT);
    end
    REC_READY = 1;
    step();
    REC_READY = 0;
    checks++;
    if (COUNT !== 4'd0 || REC_VALID !== 1'b0) begin
      fails++;
      $display("FAIL first_pop: count=%0d valid=%b required 0 0",
               COUNT, REC_VALID);
    end
  endtask

  task automatic test_threshold();
    logic [15:0] t2;
    THRESH = 2'd2; I = 0; O = 1; CE = 1; REC_READY = 0;
    LVL = 2'd0; step();
    LVL = 2'd1; step();
    LVL = 2'd2; t2 = ts_now; step();
    LVL = 2'd3; step();
    CE = 0;
    checks++;
    if (COUNT !== 4'd2 || REC_DATA !== mk(t2, 2'd2, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL thresh_head: count=%0d data=%h required 2 %h",
               COUNT, REC_DATA, mk(t2, 2'd2, 1'b1, 1'b0));
    end
    REC_READY = 1;
    step();
    checks++;
    if (COUNT !== 4'd1 || REC_DATA !== mk(t2 + 16'd1, 2'd3, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL thresh_second: count=%0d data=%h required 1 %h",
               COUNT, REC_DATA, mk(t2 + 16'd1, 2'd3, 1'b1, 1'b0));
    end
    step();
    REC_READY = 0;
    checks++;
    if (COUNT !== 4'd0) begin
      fails++;
      $display("FAIL thresh_empty: count=%0d required 0", COUNT);
    end
    THRESH = 0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] e;
    THRESH = 0; REC_READY = 1; CE = 1;
    for (int k = 0; k < 5; k++) begin
      LVL = 2'(k); I = k[0]; O = k[1];
      e = mk(ts_now, 2'(k), k[1], k[0]);
      step();
      checks++;
      if (REC_VALID !== 1'b1 || COUNT !== 4'd1 || REC_DATA !== e) begin
        fails++;
        $display("FAIL b2b[%0d]: valid=%b count=%0d data=%h required 1 1 %h",
                 k, REC_VALID, COUNT, REC_DATA, e);
      end
    end
    CE = 0;
    step();
    REC_READY = 0;
    checks++;
    if (COUNT !== 4'd0) begin
      fails++;
      $display("FAIL b2b_empty: count=%0d required 0", COUNT);
    end
  endtask

  task automatic test_overflow();
    q.delete();
    REC_READY = 0; THRESH = 0; CE = 1;
    for (int k = 0; k < 10; k++) begin
      LVL = 2'(k); I = k[0]; O = k[1];
      if (k < 8) q.push_back(mk(ts_now, 2'(k), k[1], k[0]));
      step();
    end
    CE = 0;
    checks++;
    if (COUNT !== 4'd8 || DROP_CNT !== 8'd2) begin
      fails++;
      $display("FAIL overflow: count=%0d drop=%0d required 8 2",
               COUNT, DROP_CNT);
    end
  endtask

  task automatic test_full_push_pop();
    logic [19:0] e;
    checks++;
    if (REC_DATA !== q[0]) begin
      fails++;
      $display("FAIL full_head: data=%h required %h", REC_DATA, q[0]);
    end
    CE = 1; LVL = 2'd3; I = 1; O = 1; REC_READY = 1;
    e = mk(ts_now, 2'd3, 1'b1, 1'b1);
    step();
    CE = 0;
    void'(q.pop_front());
    q.push_back(e);
    checks++;
    if (COUNT !== 4'd8 || DROP_CNT !== 8'd2) begin
      fails++;
      $display("FAIL full_pp: count=%0d drop=%0d required 8 2",
               COUNT, DROP_CNT);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (REC_VALID !== 1'b1 || REC_DATA !== q[k]) begin
        fails++;
        $display("FAIL order[%0d]: valid=%b data=%h required 1 %h",
                 k, REC_VALID, REC_DATA, q[k]);
      end
      step();
    end
    REC_READY = 0;
    checks++;
    if (COUNT !== 4'd0 || REC_VALID !== 1'b0) begin
      fails++;
      $display("FAIL order_empty: count=%0d valid=%b required 0 0",
               COUNT, REC_VALID);
    end
  endtask

  task automatic test_drop_saturate();
    CE = 0; CLR_DROP = 1;
    step();
    CLR_DROP = 0;
    checks++;
    if (DROP_CNT !== 8'd0) begin
      fails++;
      $display("FAIL clr_drop: drop=%0d required 0", DROP_CNT);
    end
    CE = 1; LVL = 0; THRESH = 0; REC_READY = 0;
    for (int k = 0; k < 8 + 255; k++) step();
    checks++;
    if (DROP_CNT !== 8'd255 || COUNT !== 4'd8) begin
      fails++;
      $display("FAIL drop_255: drop=%0d count=%0d required 255 8",
               DROP_CNT, COUNT);
    end
    step();
    checks++;
    if (DROP_CNT !== 8'd255) begin
      fails++;
      $display("FAIL drop_sat: drop=%0d required 255", DROP_CNT);
    end
    CLR_DROP = 1;
    step();
    CLR_DROP = 0;
    CE = 0;
    checks++;
    if (DROP_CNT !== 8'd1) begin
      fails++;
      $display("FAIL clr_with_drop: drop=%0d required 1", DROP_CNT);
    end
    drain();
  endtask

  task automatic test_async_reset();
    CE = 1; LVL = 2'd1; THRESH = 0; REC_READY = 0;
    for (int k = 0; k < 5; k++) step();
    CE = 0;
    checks++;
    if (COUNT !== 4'd5) begin
      fails++;
      $display("FAIL pre_reset: count=%0d required 5", COUNT);
    end
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    checks++;
    if (REC_VALID !== 1'b0 || COUNT !== 4'd0 || DROP_CNT !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%b count=%0d drop=%0d required 0",
               REC_VALID, COUNT, DROP_CNT);
    end
    release_rst();
    CE = 1; LVL = 2'd3; I = 0; O = 0;
    step();
    CE = 0;
    checks++;
    if (REC_DATA !== 20'h0000C || COUNT !== 4'd1) begin
      fails++;
      $display("FAIL ts_restart: data=%h count=%0d required 0000c 1",
               REC_DATA, COUNT);
    end
  endtask

  initial begin
    test_reset();
    test_first_event();
    test_threshold();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_drop_saturate();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
